// File: rtl/systolic_ctrl_pkg.sv
// Shared definitions for the systolic array sequencer.
//  - sa_state_e : sequencer FSM encoding
//  - SA_ROWS / SA_COLS : default array geometry
//  - drain_len() : length of the drain phase in cycles
//  - sel_w()     : width of the output column select
package systolic_ctrl_pkg;

  localparam int SA_ROWS = 8;
  localparam int SA_COLS = 8;

  typedef enum logic [2:0] {
    SA_IDLE  = 3'd0,
    SA_FEED  = 3'd1,
    SA_DRAIN = 3'd2,
    SA_WRITE = 3'd3,
    SA_DONE  = 3'd4
  } sa_state_e;

  // Drain must cover the read latency, the column skew and the psum
  // ripple down a column, plus one cycle of margin.
  function automatic int drain_len(input int rd_lat, input int cols, input int rows);
    return rd_lat + cols + rows + 1;
  endfunction

  function automatic int sel_w(input int cols);
    return (cols > 1) ? $clog2(cols) : 1;
  endfunction

endpackage

// File: rtl/systolic_ctrl_if.sv
// Command / global-buffer bus of the systolic sequencer.
//  Command : start, k, tiles, a_base, b_base, o_base  -> busy, done
//  A/B rd  : a_rd_en, a_addr, b_rd_en, b_addr, feed_vld
//  Array   : clear[COLS]
//  Out wr  : o_wr_en, o_addr, o_sel  <- o_wr_rdy
//  perf_cyc exists only when SYSTOLIC_CTRL_PERF_EN is defined.
//  slave  : sequencer side
//  master : command / buffer side
interface systolic_ctrl_if
  import systolic_ctrl_pkg::*;
#(
  parameter int COLS   = SA_COLS,
  parameter int ADDR_W = 16,
  parameter int K_W    = 16,
  parameter int T_W    = 8
) ();
  localparam int SEL_W = sel_w(COLS);

  logic              start;
  logic [K_W-1:0]    k;
  logic [T_W-1:0]    tiles;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] o_base;
  logic              busy;
  logic              done;
  logic              a_rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic              b_rd_en;
  logic [ADDR_W-1:0] b_addr;
  logic              feed_vld;
  logic [COLS-1:0]   clear;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_addr;
  logic [SEL_W-1:0]  o_sel;
  logic              o_wr_rdy;
`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0]       perf_cyc;

  modport slave (
    input  start, k, tiles, a_base, b_base, o_base, o_wr_rdy,
    output busy, done, a_rd_en, a_addr, b_rd_en, b_addr, feed_vld,
           clear, o_wr_en, o_addr, o_sel, perf_cyc
  );
  modport master (
    output start, k, tiles, a_base, b_base, o_base, o_wr_rdy,
    input  busy, done, a_rd_en, a_addr, b_rd_en, b_addr, feed_vld,
           clear, o_wr_en, o_addr, o_sel, perf_cyc
  );
`else
  modport slave (
    input  start, k, tiles, a_base, b_base, o_base, o_wr_rdy,
    output busy, done, a_rd_en, a_addr, b_rd_en, b_addr, feed_vld,
           clear, o_wr_en, o_addr, o_sel
  );
  modport master (
    output start, k, tiles, a_base, b_base, o_base, o_wr_rdy,
    input  busy, done, a_rd_en, a_addr, b_rd_en, b_addr, feed_vld,
           clear, o_wr_en, o_addr, o_sel
  );
`endif
endinterface

// File: rtl/systolic_ctrl_clear_skew.sv
// Clear skew: COLS-deep shift register turning one kick pulse into the
// staggered per-column clear vector (bit c fires c cycles after bit 0).
//  clk_i, rst_ni : clock, async active-low reset
//  kick          : one-cycle pulse, one cycle ahead of clear[0]
//  clear[COLS]   : per-column clear pulses
module systolic_ctrl_clear_skew #(
  parameter int COLS = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            kick,
  output logic [COLS-1:0] clear
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clear <= '0;
    end else begin
      clear[0] <= kick;
      for (int c = 1; c < COLS; c++) clear[c] <= clear[c-1];
    end
  end
endmodule

// File: rtl/systolic_ctrl.sv
// Sequencer for a COLS x ROWS systolic array. Per tile: feeds K operand
// words from the A/B buffers, drains with staggered column clears, then
// writes COLS result words to the output buffer.
//  clk_i, rst_ni : clock, async active-low reset (aborts a job, no done)
//  bus (slave)   : command, A/B read, clear and output-write signals
// Optional: SYSTOLIC_CTRL_PERF_EN adds perf_cyc, a saturating count of
// busy cycles cleared on each accepted start.
module systolic_ctrl
  import systolic_ctrl_pkg::*;
#(
  parameter int ROWS   = SA_ROWS,
  parameter int COLS   = SA_COLS,
  parameter int ADDR_W = 16,
  parameter int K_W    = 16,
  parameter int T_W    = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  systolic_ctrl_if.slave bus
);
  localparam int SEL_W  = sel_w(COLS);
  localparam int DLEN   = drain_len(RD_LAT, COLS, ROWS);
  localparam int D_W    = $clog2(DLEN + 1);
  localparam int KICK_D = (RD_LAT > 0) ? RD_LAT - 1 : 0;

  sa_state_e         state, state_nx;
  logic [K_W-1:0]    k_q, t_q;
  logic [T_W-1:0]    tiles_q, tile_q;
  logic [ADDR_W-1:0] a_ptr, b_ptr, o_ptr;
  logic [D_W-1:0]    d_q;
  logic [SEL_W-1:0]  c_q;
  logic              done_q;
  logic              start_ok, feed_last, drain_last, wr_acc, wr_last, tile_last;
  logic              rd_en, kick;
  logic [COLS-1:0]   clear;

  assign start_ok   = (state == SA_IDLE) && bus.start;
  assign feed_last  = (state == SA_FEED) && (t_q == k_q - K_W'(1));
  assign drain_last = (state == SA_DRAIN) && (d_q == D_W'(DLEN - 1));
  assign wr_acc     = (state == SA_WRITE) && bus.o_wr_rdy;
  assign wr_last    = wr_acc && (c_q == SEL_W'(COLS - 1));
  assign tile_last  = (tile_q == tiles_q - T_W'(1));
  assign rd_en      = (state == SA_FEED);

  // The skew register adds a cycle, so kick one cycle before clear[0]
  // is due at drain cycle RD_LAT; with no read latency that is the last
  // feed cycle.
  assign kick = (RD_LAT == 0) ? feed_last
                              : ((state == SA_DRAIN) && (d_q == D_W'(KICK_D)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= SA_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      SA_IDLE: begin
        if (bus.start) begin
          if (bus.k == '0 || bus.tiles == '0) state_nx = SA_DONE;
          else                                state_nx = SA_FEED;
        end
      end
      SA_FEED:  if (feed_last)  state_nx = SA_DRAIN;
      SA_DRAIN: if (drain_last) state_nx = SA_WRITE;
      SA_WRITE: if (wr_last)    state_nx = tile_last ? SA_DONE : SA_FEED;
      SA_DONE:  state_nx = SA_IDLE;
      default:  state_nx = SA_IDLE;
    endcase
  end

  // Address pointers run continuously across tiles, which yields
  // base + tile*K + t and base + tile*COLS + c without multipliers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      k_q     <= '0;
      tiles_q <= '0;
      tile_q  <= '0;
      t_q     <= '0;
      d_q     <= '0;
      c_q     <= '0;
      a_ptr   <= '0;
      b_ptr   <= '0;
      o_ptr   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == SA_DONE);
      if (start_ok) begin
        k_q     <= bus.k;
        tiles_q <= bus.tiles;
        a_ptr   <= bus.a_base;
        b_ptr   <= bus.b_base;
        o_ptr   <= bus.o_base;
        tile_q  <= '0;
        t_q     <= '0;
        d_q     <= '0;
        c_q     <= '0;
      end
      if (rd_en) begin
        a_ptr <= a_ptr + ADDR_W'(1);
        b_ptr <= b_ptr + ADDR_W'(1);
        t_q   <= feed_last ? '0 : t_q + K_W'(1);
      end
      if (state == SA_DRAIN) d_q <= drain_last ? '0 : d_q + D_W'(1);
      if (wr_acc) begin
        o_ptr <= o_ptr + ADDR_W'(1);
        c_q   <= wr_last ? '0 : c_q + SEL_W'(1);
        if (wr_last) tile_q <= tile_q + T_W'(1);
      end
    end
  end

  // feed_vld follows a_rd_en through the buffer read latency.
  if (RD_LAT == 0) begin : g_nolat
    assign bus.feed_vld = rd_en;
  end else begin : g_lat
    logic [RD_LAT-1:0] vld_pipe;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= rd_en;
        for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
    end
    assign bus.feed_vld = vld_pipe[RD_LAT-1];
  end

  systolic_ctrl_clear_skew #(.COLS(COLS)) u_skew (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .kick   (kick),
    .clear  (clear)
  );

  assign bus.clear   = clear;
  assign bus.busy    = (state != SA_IDLE);
  assign bus.done    = done_q;
  assign bus.a_rd_en = rd_en;
  assign bus.b_rd_en = rd_en;
  assign bus.a_addr  = a_ptr;
  assign bus.b_addr  = b_ptr;
  assign bus.o_wr_en = (state == SA_WRITE);
  assign bus.o_addr  = o_ptr;
  assign bus.o_sel   = c_q;

`ifdef SYSTOLIC_CTRL_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                perf_q <= '0;
    else if (start_ok)                          perf_q <= '0;
    else if (state != SA_IDLE && perf_q != '1)  perf_q <= perf_q + 32'd1;
  end
  assign bus.perf_cyc = perf_q;
`endif

endmodule
